// File: rtl/model_matrix_sequencer_if.sv
// Matrix hand-off bus between the model-matrix sequencer and the MVP multiply stage.
interface model_matrix_sequencer_if #(
  parameter int CFG_W = 16
);
  logic [16*CFG_W-1:0] matrix_out;
  logic                matrix_valid;
  logic                matrix_ready;

  modport master (output matrix_out, output matrix_valid, input matrix_ready);
  modport slave  (input matrix_out, input matrix_valid, output matrix_ready);
endinterface

// File: rtl/model_matrix_sequencer.sv
// Per-frame model-matrix controller: Y-rotation angle stepping, settle wait and valid/ready hand-off.
// Define MODEL_SEQ_STATUS_EN to add the frame_count / overrun_count status outputs.

module get_model_matrix #(
  parameter int ANGLE_W = 12,
  parameter int CFG_W   = 16
) (
  input  logic [ANGLE_W-1:0]   angle,
  input  logic [CFG_W-1:0]     scale,
  input  logic [CFG_W-1:0]     x,
  input  logic [CFG_W-1:0]     y,
  input  logic [CFG_W-1:0]     z,
  output logic [16*CFG_W-1:0]  matrix
);
  // Angles are radians scaled by 256; pi is approximated as 804.
  localparam logic signed [ANGLE_W:0]   PI_Q      = (ANGLE_W+1)'(804);
  localparam logic signed [ANGLE_W:0]   HALF_PI_Q = (ANGLE_W+1)'(402);
  localparam logic signed [ANGLE_W:0]   TWO_PI_Q  = (ANGLE_W+1)'(1608);
  localparam logic signed [2*CFG_W-1:0] HALF_LSB  = (2*CFG_W)'(128);
  localparam logic [CFG_W-1:0]          ONE       = CFG_W'(256);

  // Fold to [-pi/2, pi/2], then a 7th-order odd polynomial evaluated in Q.14.
  function automatic logic signed [CFG_W-1:0] sin_q(input logic signed [ANGLE_W:0] a_in);
    logic signed [ANGLE_W:0] a;
    logic signed [31:0] xq, x2, t, s;
    a = a_in;
    if (a > HALF_PI_Q)
      a = PI_Q - a;
    else if (a < -HALF_PI_Q)
      a = -PI_Q - a;
    xq = 32'(a) <<< 6;
    x2 = (xq * xq) >>> 14;
    t  = 32'sd16384 - ((x2 * 32'sd390) >>> 14);
    t  = 32'sd16384 - ((((x2 * t) >>> 14) * 32'sd819) >>> 14);
    t  = 32'sd16384 - ((((x2 * t) >>> 14) * 32'sd2731) >>> 14);
    s  = (xq * t) >>> 14;
    return CFG_W'((s + 32'sd32) >>> 6);
  endfunction

  logic signed [ANGLE_W:0]   ang_ext;
  logic signed [ANGLE_W:0]   cos_arg;
  logic signed [CFG_W-1:0]   sin_v;
  logic signed [CFG_W-1:0]   cos_v;
  logic signed [2*CFG_W-1:0] prod_c;
  logic signed [2*CFG_W-1:0] prod_s;
  logic signed [CFG_W-1:0]   sc_cos;
  logic signed [CFG_W-1:0]   sc_sin;
  logic [CFG_W-1:0]          elem [16];

  always_comb begin
    ang_ext = {angle[ANGLE_W-1], angle};
    cos_arg = ang_ext + HALF_PI_Q;
    if (cos_arg >= PI_Q)
      cos_arg = cos_arg - TWO_PI_Q;
    sin_v  = sin_q(ang_ext);
    cos_v  = sin_q(cos_arg);
    prod_c = $signed(scale) * cos_v;
    prod_s = $signed(scale) * sin_v;
    sc_cos = CFG_W'((prod_c + HALF_LSB) >>> 8);
    sc_sin = CFG_W'((prod_s + HALF_LSB) >>> 8);
    for (int i = 0; i < 16; i++)
      elem[i] = '0;
    elem[0]  = sc_cos;
    elem[2]  = sc_sin;
    elem[3]  = x;
    elem[5]  = scale;
    elem[7]  = y;
    elem[8]  = -sc_sin;
    elem[10] = sc_cos;
    elem[11] = z;
    elem[15] = ONE;
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pack
      assign matrix[gi*CFG_W +: CFG_W] = elem[gi];
    end
  endgenerate
endmodule

module model_matrix_sequencer #(
  parameter int                 ANGLE_W       = 12,
  parameter int                 CFG_W         = 16,
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [ANGLE_W-1:0] ANGLE_INIT    = 12'h000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               rotate_en,
  input  logic [ANGLE_W-1:0] angle_step,
  input  logic [CFG_W-1:0]   scale_in,
  input  logic [CFG_W-1:0]   x_in,
  input  logic [CFG_W-1:0]   y_in,
  input  logic [CFG_W-1:0]   z_in,
  model_matrix_sequencer_if.master mbus,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               busy
`ifdef MODEL_SEQ_STATUS_EN
  ,
  output logic [15:0]        frame_count,
  output logic [7:0]         overrun_count
`endif
);
  localparam logic signed [ANGLE_W:0] PI_Q     = (ANGLE_W+1)'(804);
  localparam logic signed [ANGLE_W:0] TWO_PI_Q = (ANGLE_W+1)'(1608);

  typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg;
  logic [ANGLE_W-1:0]      angle_reg;
  logic [CFG_W-1:0]        scale_reg, x_reg, y_reg, z_reg;
  logic [16*CFG_W-1:0]     matrix_reg;
  logic [16*CFG_W-1:0]     dp_matrix;
  logic                    valid_reg;
  logic                    accept, capture, handoff, overrun;
  logic signed [ANGLE_W:0] angle_sum;
  logic [ANGLE_W-1:0]      angle_next;

  // The datapath only ever sees registered state, so live inputs cannot disturb a matrix.
  get_model_matrix #(.ANGLE_W(ANGLE_W), .CFG_W(CFG_W)) u_datapath (
    .angle  (angle_reg),
    .scale  (scale_reg),
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .matrix (dp_matrix)
  );

  always_comb begin
    angle_sum = {angle_reg[ANGLE_W-1], angle_reg} + {angle_step[ANGLE_W-1], angle_step};
    if (angle_sum >= PI_Q)
      angle_next = ANGLE_W'(angle_sum - TWO_PI_Q);
    else if (angle_sum < -PI_Q)
      angle_next = ANGLE_W'(angle_sum + TWO_PI_Q);
    else
      angle_next = ANGLE_W'(angle_sum);
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    handoff    = 1'b0;
    overrun    = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        overrun = frame_start;
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        overrun = frame_start;
        if (mbus.matrix_ready) begin
          handoff    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      angle_reg  <= ANGLE_INIT;
      scale_reg  <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      matrix_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (rotate_en)
          angle_reg <= angle_next;
        scale_reg <= scale_in;
        x_reg     <= x_in;
        y_reg     <= y_in;
        z_reg     <= z_in;
        cnt_reg   <= 4'(SETTLE_CYCLES - 1);
      end else if (state_reg == SETTLE && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture) begin
        matrix_reg <= dp_matrix;
        valid_reg  <= 1'b1;
      end else if (handoff) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef MODEL_SEQ_STATUS_EN
  logic [15:0] frame_count_reg;
  logic [7:0]  overrun_count_reg;

  // Frame count wraps; overrun count saturates so a stuck consumer stays visible.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_count_reg   <= 16'd0;
      overrun_count_reg <= 8'd0;
    end else begin
      if (accept)
        frame_count_reg <= frame_count_reg + 16'd1;
      if (overrun && overrun_count_reg != 8'hFF)
        overrun_count_reg <= overrun_count_reg + 8'd1;
    end
  end

  assign frame_count   = frame_count_reg;
  assign overrun_count = overrun_count_reg;
`endif

  assign mbus.matrix_out   = matrix_reg;
  assign mbus.matrix_valid = valid_reg;
  assign angle_out         = angle_reg;
endmodule

// File: tb/tb_model_matrix_sequencer.sv
// Bench for model_matrix_sequencer: real-math reference model, per-cycle compare, directed and random frames.
module tb_model_matrix_sequencer;
  localparam int AW     = 12;
  localparam int CW     = 16;
  localparam int SETTLE = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          rotate_en = 1'b0;
  logic [AW-1:0] angle_step = '0;
  logic [CW-1:0] scale_in = '0, x_in = '0, y_in = '0, z_in = '0;
  logic [AW-1:0] angle_out;
  logic          busy;
`ifdef MODEL_SEQ_STATUS_EN
  logic [15:0]   frame_count;
  logic [7:0]    overrun_count;
`endif

  model_matrix_sequencer_if #(.CFG_W(CW)) mbus ();

  always #5 Clk = ~Clk;

  model_matrix_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .rotate_en   (rotate_en),
    .angle_step  (angle_step),
    .scale_in    (scale_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .mbus        (mbus.master),
    .angle_out   (angle_out),
    .busy        (busy)
`ifdef MODEL_SEQ_STATUS_EN
    ,
    .frame_count   (frame_count),
    .overrun_count (overrun_count)
`endif
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model: frame timeline plus the parameters of the matrix currently on the bus.
  int m_angle = 0;
  bit m_busy = 0, m_valid = 0, m_zero = 1;
  int m_deliver = 0, edge_no = 0;
  int m_fc = 0, m_oc = 0;
  int snap_a = 0, snap_s = 0, snap_x = 0, snap_y = 0, snap_z = 0;
  int sh_a = 0, sh_s = 0, sh_x = 0, sh_y = 0, sh_z = 0;

  function automatic int sx16(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int sx12(input logic [11:0] v);
    logic signed [11:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrap_angle(input int a, input int st);
    int s;
    s = a + st;
    if (s >= 804) s = s - 1608;
    else if (s < -804) s = s + 1608;
    return s;
  endfunction

  function automatic void expect_elem(input int i, output int v, output int tol);
    real ar, sc;
    int  as;
    v = 0;
    tol = 0;
    if (!m_zero) begin
      ar = real'(sh_a) / 256.0;
      sc = real'(sh_s) / 256.0;
      as = (sh_s < 0) ? -sh_s : sh_s;
      case (i)
        0, 10: begin v = int'(sc * $cos(ar) * 256.0);  tol = 2 + as / 256; end
        2:     begin v = int'(sc * $sin(ar) * 256.0);  tol = 2 + as / 256; end
        8:     begin v = int'(-sc * $sin(ar) * 256.0); tol = 2 + as / 256; end
        3:  v = sh_x;
        5:  v = sh_s;
        7:  v = sh_y;
        11: v = sh_z;
        15: v = 256;
        default: v = 0;
      endcase
    end
  endfunction

  function automatic int elem(input int i);
    return sx16(mbus.matrix_out[i*16 +: 16]);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  initial forever begin
    @(posedge Clk or posedge Reset);
    if (Reset) begin
      m_angle = 0; m_busy = 0; m_valid = 0; m_zero = 1; m_fc = 0; m_oc = 0;
    end else begin
      edge_no++;
      if (m_busy) begin
        if (frame_start) m_oc = (m_oc == 255) ? 255 : m_oc + 1;
        if (m_valid && mbus.matrix_ready) begin
          m_busy = 0;
          m_valid = 0;
          $display("xfer angle=%0d scale=%0d x=%0d y=%0d z=%0d", sh_a, sh_s, sh_x, sh_y, sh_z);
        end else if (!m_valid && edge_no == m_deliver) begin
          m_valid = 1; m_zero = 0;
          sh_a = snap_a; sh_s = snap_s; sh_x = snap_x; sh_y = snap_y; sh_z = snap_z;
        end
      end else if (frame_start) begin
        if (rotate_en) m_angle = wrap_angle(m_angle, sx12(angle_step));
        snap_a = m_angle; snap_s = sx16(scale_in);
        snap_x = sx16(x_in); snap_y = sx16(y_in); snap_z = sx16(z_in);
        m_deliver = edge_no + SETTLE;
        m_busy = 1;
        m_fc = (m_fc + 1) % 65536;
      end
    end
  end

  initial forever begin
    int first, fa, fe, av, ev, tl;
    @(negedge Clk);
    if (chk_en) begin
      check("valid", mbus.matrix_valid, m_valid);
      check("busy", busy, m_busy);
      check("angle", sx12(angle_out), m_angle);
      first = -1; fa = 0; fe = 0;
      for (int i = 0; i < 16; i++) begin
        expect_elem(i, ev, tl);
        av = elem(i);
        if (first < 0 && (av - ev > tl || ev - av > tl)) begin
          first = i; fa = av; fe = ev;
        end
      end
      total++;
      if (first >= 0) begin
        bad++;
        $display("FAIL matrix elem%0d actual=%0d required=%0d", first, fa, fe);
      end
`ifdef MODEL_SEQ_STATUS_EN
      check("frame_count", frame_count, m_fc);
      check("overrun_count", overrun_count, m_oc);
`endif
    end
  end

  task automatic strobe(input int st, input bit rot, input int sc, input int x, input int y, input int z);
    @(negedge Clk);
    frame_start = 1'b1;
    rotate_en   = rot;
    angle_step  = 12'(st);
    scale_in    = 16'(sc);
    x_in        = 16'(x);
    y_in        = 16'(y);
    z_in        = 16'(z);
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!mbus.matrix_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("valid_timeout", mbus.matrix_valid, 1);
  endtask

  task automatic run_frame(input int st, input bit rot, input int sc, input int x, input int y, input int z);
    strobe(st, rot, sc, x, y, z);
    wait_valid();
  endtask

  task automatic drain();
    int n;
    frame_start = 1'b0;
    mbus.matrix_ready = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("drain_idle", busy, 0);
  endtask

  initial begin
    logic [16*CW-1:0] held;
    logic [AW-1:0]    held_angle;
    int               st, sc;
    mbus.matrix_ready = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    @(negedge Clk);
    check("rst_valid", mbus.matrix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_angle", angle_out, 0);
    check("rst_matrix_nonzero", (mbus.matrix_out != '0), 0);

    // Identity rotation with translation, exact latency and one-cycle pulse.
    mbus.matrix_ready = 1'b1;
    strobe(0, 1, 16'h0100, 16'h0200, 0, 0);
    check("t1_lat0", mbus.matrix_valid, 0);
    @(negedge Clk);
    check("t1_lat1", mbus.matrix_valid, 0);
    @(negedge Clk);
    check("t1_valid", mbus.matrix_valid, 1);
    check("t1_e0", elem(0), 256);
    check("t1_e10", elem(10), 256);
    check("t1_e2", elem(2), 0);
    check("t1_e8", elem(8), 0);
    check("t1_e5", elem(5), 256);
    check("t1_e3", elem(3), 512);
    check("t1_e15", elem(15), 256);
    @(negedge Clk);
    check("t1_pulse", mbus.matrix_valid, 0);
    check("t1_idle", busy, 0);

    // Quarter turn.
    run_frame(16'h192, 1, 16'h0100, 0, 0, 0);
    check("t2_angle", angle_out, 12'h192);
    check_range("t2_e2", elem(2), 255, 257);
    check_range("t2_e8", elem(8), -257, -255);
    check_range("t2_e0", elem(0), -1, 1);
    @(negedge Clk);

    // Wrap-around at +pi and -pi.
    run_frame(16'h18A, 1, 16'h0100, 0, 0, 0);
    check("t3_angle_31c", angle_out, 12'h31C);
    @(negedge Clk);
    run_frame(16'h010, 1, 16'h0100, 0, 0, 0);
    check("t3_wrap_pos", angle_out, 12'hCE4);
    @(negedge Clk);
    run_frame(-8, 1, 16'h0100, 0, 0, 0);
    check("t3_angle_cdc", angle_out, 12'hCDC);
    @(negedge Clk);
    run_frame(-16, 1, 16'h0100, 0, 0, 0);
    check("t3_wrap_neg", angle_out, 12'h314);
    @(negedge Clk);

    // rotate_en low: angle held, config still taken.
    run_frame(100, 0, 16'h0180, 7, 8, 9);
    check("t5_angle_hold", angle_out, 12'h314);
    check("t5_scale", elem(5), 16'h0180);
    check("t5_z", elem(11), 9);
    @(negedge Clk);

    // Back-pressure with overrun strobes and config churn.
    mbus.matrix_ready = 1'b0;
    run_frame(32, 1, 16'h0180, 1, 2, 3);
    held = mbus.matrix_out;
    held_angle = angle_out;
    for (int k = 0; k < 10; k++) begin
      frame_start = (k == 2 || k == 5);
      scale_in = 16'($urandom);
      @(negedge Clk);
      check("t4_stable", (mbus.matrix_out == held), 1);
      check("t4_valid_hold", mbus.matrix_valid, 1);
      check("t4_angle_hold", angle_out, held_angle);
    end
    frame_start = 1'b0;
`ifdef MODEL_SEQ_STATUS_EN
    check("t4_overruns", overrun_count, 2);
`endif
    mbus.matrix_ready = 1'b1;
    @(negedge Clk);
    check("t4_release_valid", mbus.matrix_valid, 0);
    check("t4_release_idle", busy, 0);

    // Random traffic including overruns and stalls.
    for (int n = 0; n < 1500; n++) begin
      @(negedge Clk);
      frame_start = ($urandom_range(0, 3) == 0);
      rotate_en   = 1'($urandom_range(0, 1));
      st = int'($urandom_range(0, 1606)) - 803;
      sc = int'($urandom_range(0, 2048)) - 1024;
      angle_step = st[11:0];
      scale_in   = sc[15:0];
      x_in = 16'($urandom);
      y_in = 16'($urandom);
      z_in = 16'($urandom);
      mbus.matrix_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge Clk);
    drain();

    // Reset in the middle of a settle interval.
    strobe(256, 1, 16'h0100, 5, 5, 5);
    #2 Reset = 1'b1;
    #1;
    check("t7_async_angle", angle_out, 12'h000);
    check("t7_async_valid", mbus.matrix_valid, 0);
    check("t7_async_busy", busy, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      check("t7_no_valid", mbus.matrix_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
